// File: rtl/scan_page_scheduler.sv
// scan_page_scheduler: ping-pong Scan RAM page owner; swaps on joint packet completion
// and streams the completed page, channel A then channel B, over a valid/ready byte port.
module scan_page_scheduler #(
  parameter int IDX_W  = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              packet_formed_a_i,
  input  logic              packet_formed_b_i,
  input  logic              wren_a_i,
  input  logic              wren_b_i,
  input  logic [IDX_W:0]    wr_addr_a_i,
  input  logic [IDX_W:0]    wr_addr_b_i,
  output logic              ram_page_o,
  output logic [IDX_W:0]    rd_addr_a_o,
  output logic [IDX_W:0]    rd_addr_b_o,
  input  logic [DATA_W-1:0] rd_data_a_i,
  input  logic [DATA_W-1:0] rd_data_b_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic              m_chan_o,
  output logic              busy_o,
  output logic [15:0]       drop_cnt_o
);
  localparam int AW = IDX_W + 1;
  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_WAIT, OUT} state_t;
  state_t state, state_n;
  logic [AW-1:0] len_wa, len_wb, len_ra, len_rb, nxt_a, nxt_b, cur_len;
  logic [IDX_W-1:0] rd_idx;
  logic both, both_q, evt;
  // trackers with same-cycle write bypass so a write coinciding with the swap is kept
  assign nxt_a = (wren_a_i && wr_addr_a_i[IDX_W] == ram_page_o) ? {1'b0, wr_addr_a_i[IDX_W-1:0]} + AW'(1) : len_wa;
  assign nxt_b = (wren_b_i && wr_addr_b_i[IDX_W] == ram_page_o) ? {1'b0, wr_addr_b_i[IDX_W-1:0]} + AW'(1) : len_wb;
  assign both = packet_formed_a_i & packet_formed_b_i;
  assign evt = both & ~both_q;
  assign cur_len = m_chan_o ? len_rb : len_ra;
  assign rd_addr_a_o = {~ram_page_o, rd_idx};
  assign rd_addr_b_o = {~ram_page_o, rd_idx};
  assign busy_o = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (evt && (nxt_a != '0 || nxt_b != '0)) ? RD_ADDR : IDLE;
      RD_ADDR: state_n = RD_WAIT;
      RD_WAIT: state_n = OUT;
      OUT:     state_n = !m_ready_i ? OUT : (!m_last_o || (!m_chan_o && len_rb != '0)) ? RD_ADDR : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      both_q     <= 1'b0;
      ram_page_o <= 1'b0;
      len_wa     <= '0;
      len_wb     <= '0;
      len_ra     <= '0;
      len_rb     <= '0;
      rd_idx     <= '0;
      m_data_o   <= '0;
      m_valid_o  <= 1'b0;
      m_last_o   <= 1'b0;
      m_chan_o   <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      both_q <= both;
      if (evt && state == IDLE) begin
        ram_page_o <= ~ram_page_o;
        len_ra     <= nxt_a;
        len_rb     <= nxt_b;
        len_wa     <= '0;
        len_wb     <= '0;
        rd_idx     <= '0;
        m_chan_o   <= nxt_a == '0;
      end else if (evt) begin
        // overrun: the page being written is reused in place
        len_wa <= '0;
        len_wb <= '0;
        if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
      end else begin
        len_wa <= nxt_a;
        len_wb <= nxt_b;
      end
      if (state == RD_WAIT) begin
        m_data_o  <= m_chan_o ? rd_data_b_i : rd_data_a_i;
        m_valid_o <= 1'b1;
        m_last_o  <= {1'b0, rd_idx} == cur_len - AW'(1);
      end
      if (state == OUT && m_ready_i) begin
        m_valid_o <= 1'b0;
        if (!m_last_o) rd_idx <= rd_idx + 1'b1;
        else if (!m_chan_o && len_rb != '0) begin
          m_chan_o <= 1'b1;
          rd_idx   <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_scan_page_scheduler.sv
// tb_scan_page_scheduler: directed + randomized bench with behavioural Scan RAMs and a
// stream model built from the bytes written per page.
module tb_scan_page_scheduler;
  logic clk = 0, rst = 1, pfa = 0, pfb = 0, wra = 0, wrb = 0, ready = 1;
  logic [7:0] waa = 0, wab = 0, wda = 0, wdb = 0, rda, rdb;
  logic [7:0] rd_addr_a, rd_addr_b, m_data;
  logic ram_page, m_valid, m_last, m_chan, busy;
  logic [15:0] drop_cnt;
  logic [7:0] rama [256];
  logic [7:0] ramb [256];
  typedef struct {int cyc; logic chan; logic last; logic [7:0] data;} rec_t;
  rec_t got[$];
  rec_t exp[$];
  int cyc = 0, errs = 0, checks = 0;
  logic mp = 0;

  scan_page_scheduler dut (
    .clk_i(clk), .rst_i(rst),
    .packet_formed_a_i(pfa), .packet_formed_b_i(pfb),
    .wren_a_i(wra), .wren_b_i(wrb),
    .wr_addr_a_i(waa), .wr_addr_b_i(wab),
    .ram_page_o(ram_page),
    .rd_addr_a_o(rd_addr_a), .rd_addr_b_o(rd_addr_b),
    .rd_data_a_i(rda), .rd_data_b_i(rdb),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(ready),
    .m_last_o(m_last), .m_chan_o(m_chan),
    .busy_o(busy), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (wra) rama[waa] <= wda;
    if (wrb) ramb[wab] <= wdb;
    rda <= rama[rd_addr_a];
    rdb <= ramb[rd_addr_b];
  end
  always @(negedge clk) begin
    #1;
    if (!rst && m_valid && ready) got.push_back('{cyc, m_chan, m_last, m_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Writes na bytes to A and nb to B (idx 0..n-1) on the model page, then pulses formed.
  task automatic write_pkt(input int na, input int nb, input bit byp, input bit fixed);
    logic [7:0] da[$];
    logic [7:0] db[$];
    int n = na > nb ? na : nb;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wra = i < na;
      wrb = i < nb;
      waa = {mp, 7'(i)};
      wab = {mp, 7'(i)};
      wda = fixed ? 8'(10 + i) : 8'($urandom);
      wdb = fixed ? 8'(20 + i) : 8'($urandom);
      if (i < na) da.push_back(wda);
      if (i < nb) db.push_back(wdb);
      if (byp && i == n - 1) begin pfa = 1; pfb = 1; end
    end
    if (!(byp && n > 0)) begin
      @(negedge clk);
      wra = 0; wrb = 0;
      pfa = 1; pfb = 1;
    end
    @(negedge clk);
    wra = 0; wrb = 0; pfa = 0; pfb = 0;
    for (int i = 0; i < na; i++) exp.push_back('{0, 1'b0, i == na - 1, da[i]});
    for (int i = 0; i < nb; i++) exp.push_back('{0, 1'b1, i == nb - 1, db[i]});
    mp = ~mp;
  endtask

  task automatic drain(input bit rnd);
    int k = 0;
    while ((got.size() < exp.size() || busy) && k < 3000) begin
      @(negedge clk);
      if (rnd) ready = 1'($urandom_range(0, 1));
      k++;
    end
    ready = 1;
    chk("stream_len", got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk($sformatf("data[%0d]", i), got[i].data, exp[i].data);
      chk($sformatf("last[%0d]", i), got[i].last, exp[i].last);
      chk($sformatf("chan[%0d]", i), got[i].chan, exp[i].chan);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_page"}, ram_page, 0);
    chk({tag, "_rda"}, rd_addr_a, 8'h80);
    chk({tag, "_rdb"}, rd_addr_b, 8'h80);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_last"}, m_last, 0);
    chk({tag, "_chan"}, m_chan, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
  endtask

  initial begin
    logic [7:0] hd;
    logic hl, hc;
    int k;
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 0;
    // basic stream with first-byte latency and 3-cycle spacing
    write_pkt(4, 2, 0, 1);
    chk("basic_page", ram_page, mp);
    chk("basic_busy", busy, 1);
    chk("basic_v0", m_valid, 0);
    @(negedge clk);
    chk("basic_v1", m_valid, 0);
    @(negedge clk);
    chk("basic_v2", m_valid, 1);
    chk("basic_first", m_data, 10);
    drain(0);
    for (int i = 1; i < got.size(); i++) chk($sformatf("gap[%0d]", i), got[i].cyc - got[i-1].cyc, 3);
    got.delete(); exp.delete();
    // backpressure on the third byte
    write_pkt(4, 2, 0, 0);
    k = 0;
    while (got.size() < 2 && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    ready = 0;
    k = 0;
    while (!m_valid && k < 100) begin @(negedge clk); k++; end
    chk("bp_valid", m_valid, 1);
    hd = m_data; hl = m_last; hc = m_chan;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_v", m_valid, 1);
      chk("bp_hold_d", m_data, hd);
      chk("bp_hold_l", m_last, hl);
      chk("bp_hold_c", m_chan, hc);
    end
    ready = 1;
    drain(0);
    chk("bp_gap", got[3].cyc - got[2].cyc, 3);
    got.delete(); exp.delete();
    // overrun during readout
    write_pkt(5, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wra = 1; waa = {mp, 7'(i)}; wda = 8'($urandom);
    end
    @(negedge clk);
    wra = 0; pfa = 1; pfb = 1;
    @(negedge clk);
    pfa = 0; pfb = 0;
    chk("ovr_page", ram_page, mp);
    chk("ovr_drop", drop_cnt, 1);
    chk("ovr_busy", busy, 1);
    drain(0);
    got.delete(); exp.delete();
    // trackers cleared by overrun, plus a write to the other page: nothing to read
    @(negedge clk);
    wra = 1; waa = {~mp, 7'd40}; wda = 8'h55;
    @(negedge clk);
    wra = 0;
    write_pkt(0, 0, 0, 0);
    chk("empty_page", ram_page, mp);
    for (int i = 0; i < 4; i++) begin
      chk("empty_busy", busy, 0);
      chk("empty_valid", m_valid, 0);
      @(negedge clk);
    end
    // channel A empty
    write_pkt(0, 3, 0, 0);
    chk("a0_page", ram_page, mp);
    drain(0);
    got.delete(); exp.delete();
    // randomized packets, bypass writes, random backpressure
    for (int it = 0; it < 8; it++) begin
      write_pkt($urandom_range(0, 24), $urandom_range(0, 24), 1'($urandom_range(0, 1)), 0);
      chk("rnd_page", ram_page, mp);
      drain(1);
      got.delete(); exp.delete();
    end
    // full 128-byte page
    write_pkt(128, 0, 0, 0);
    drain(0);
    got.delete(); exp.delete();
    // async reset mid-stream
    write_pkt(10, 10, 0, 0);
    k = 0;
    while (got.size() < 3 && k < 100) begin @(negedge clk); k++; end
    chk("pre_rst_drop", drop_cnt, 1);
    @(negedge clk);
    while (!m_valid && k < 200) begin @(negedge clk); k++; end
    #3;
    rst = 1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 0;
    mp = 0;
    got.delete(); exp.delete();
    write_pkt(2, 2, 0, 0);
    chk("post_rst_page", ram_page, 1);
    drain(0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
